// File: rtl/fp_bf25_pkg.sv
// Shared definitions for the 25-bit float datapath (sign, 8-bit biased exponent, 16-bit mantissa).
// Holds the field widths, the bias, the field-extract helpers and the divider FSM state type.
// The multiplier and the divider both import this package so the format stays in one place.
package fp_bf25_pkg;

    localparam int EXP_W   = 8;
    localparam int MAN_W   = 16;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;

    localparam int FP_W  = 1 + EXP_W + MAN_W;
    localparam int Q_W   = MAN_W + 3;      // quotient bits produced by the divider
    localparam int R_W   = MAN_W + 2;      // partial remainder width
    localparam int E_W   = EXP_W + 2;      // signed exponent working width
    localparam int CNT_W = $clog2(Q_W);

    typedef logic [FP_W-1:0] fp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2
    } div_state_t;

    function automatic logic fp_sign(fp_t v);
        return v[FP_W-1];
    endfunction

    function automatic logic [EXP_W-1:0] fp_exp(fp_t v);
        return v[FP_W-2:MAN_W];
    endfunction

    function automatic logic [MAN_W-1:0] fp_man(fp_t v);
        return v[MAN_W-1:0];
    endfunction

    // A zero exponent means zero; the mantissa bits are don't-care.
    function automatic logic fp_is_zero(fp_t v);
        return (fp_exp(v) == '0);
    endfunction

endpackage

// File: rtl/fp_division_bfloat16_if.sv
// Operand/result handshake bundle for the divider.
// Ports: values_rdy/fp_value_1/fp_value_2 from the producer, in_ready back to it;
// result_rdy/result towards the consumer. master = producer side, slave = divider side.
interface fp_division_bfloat16_if;
    import fp_bf25_pkg::*;

    logic values_rdy;
    logic in_ready;
    fp_t  fp_value_1;
    fp_t  fp_value_2;
    logic result_rdy;
    fp_t  result;

    modport master (
        output values_rdy, fp_value_1, fp_value_2,
        input  in_ready, result_rdy, result
    );

    modport slave (
        input  values_rdy, fp_value_1, fp_value_2,
        output in_ready, result_rdy, result
    );

endinterface

// File: rtl/fp_mantissa_divider_seq.sv
// Restoring mantissa divider, one quotient bit per cycle, MSB first.
// Ports: start loads dividend/divisor; quotient is valid after the cycle where last=1.
// Latency Q_W cycles after start; no backpressure, start always restarts it.
module fp_mantissa_divider_seq
    import fp_bf25_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [MAN_W:0]   dividend,
    input  logic [MAN_W:0]   divisor,
    output logic [Q_W-1:0]   quotient,
    output logic             last
);

    logic [R_W-1:0]   rem;
    logic [MAN_W:0]   den;
    logic [CNT_W-1:0] cnt;
    logic             busy;
    logic [R_W:0]     diff;
    logic             q_bit;

    // Borrow out of the trial subtraction decides the quotient bit.
    assign diff  = {1'b0, rem} - {2'b00, den};
    assign q_bit = ~diff[R_W];
    assign last  = busy && (cnt == CNT_W'(Q_W - 1));

    // After a successful subtract the remainder is below den (< 2^(MAN_W+1)),
    // so dropping its top bit before the shift loses nothing.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rem      <= '0;
            den      <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            quotient <= '0;
        end else if (start) begin
            rem      <= {1'b0, dividend};
            den      <= divisor;
            cnt      <= '0;
            busy     <= 1'b1;
            quotient <= '0;
        end else if (busy) begin
            quotient <= {quotient[Q_W-2:0], q_bit};
            rem      <= q_bit ? {diff[R_W-2:0], 1'b0} : {rem[R_W-2:0], 1'b0};
            cnt      <= cnt + 1'b1;
            if (last) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fp_division_bfloat16.sv
// Iterative 25-bit float divider: result = fp_value_1 / fp_value_2, flush-to-zero, round-half-up.
// Ports: clk, rstn (sync, active-low), bus (slave handshake). Fixed latency MAN_W+4 edges after accept.
// in_ready only in IDLE; strobes while busy are dropped, result held until the next result_rdy pulse.
module fp_division_bfloat16
    import fp_bf25_pkg::*;
(
    input  logic                  clk,
    input  logic                  rstn,
    fp_division_bfloat16_if.slave bus
);

    div_state_t        state, state_nxt;
    logic              accept;
    logic              in_ready;
    logic              load_result;
    logic              div_last;
    logic [Q_W-1:0]    quot;

    logic              sgn;
    logic [EXP_W-1:0]  exp_a, exp_b;
    logic              zero_a, zero_b;

    fp_t               result_q;
    logic              result_rdy_q;
    fp_t               result_nxt;

    logic signed [E_W-1:0] e_base, e_pre, e_rnd;
    logic [MAN_W-1:0]      mant, mant_rnd;
    logic                  guard, carry;

    localparam logic signed [E_W-1:0] E_MAX_S = E_W'(EXP_MAX);

    fp_mantissa_divider_seq u_mant_div (
        .clk      (clk),
        .rstn     (rstn),
        .start    (accept),
        .dividend ({1'b1, fp_man(bus.fp_value_1)}),
        .divisor  ({1'b1, fp_man(bus.fp_value_2)}),
        .quotient (quot),
        .last     (div_last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.values_rdy) state_nxt = DIV;
            DIV:     if (div_last)       state_nxt = NORM;
            NORM:                        state_nxt = IDLE;
            default:                     state_nxt = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        in_ready    = (state == IDLE);
        accept      = (state == IDLE) && bus.values_rdy;
        load_result = (state == NORM);
    end

    // Operand side-information captured at accept; the mantissas live in the divider.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sgn    <= 1'b0;
            exp_a  <= '0;
            exp_b  <= '0;
            zero_a <= 1'b0;
            zero_b <= 1'b0;
        end else if (accept) begin
            sgn    <= fp_sign(bus.fp_value_1) ^ fp_sign(bus.fp_value_2);
            exp_a  <= fp_exp(bus.fp_value_1);
            exp_b  <= fp_exp(bus.fp_value_2);
            zero_a <= fp_is_zero(bus.fp_value_1);
            zero_b <= fp_is_zero(bus.fp_value_2);
        end
    end

    assign e_base = $signed({2'b00, exp_a}) - $signed({2'b00, exp_b}) + $signed(E_W'(BIAS));

    // Quotient of two [1,2) mantissas lies in (0.5,2): its top bit picks the normalising shift.
    always_comb begin
        if (quot[Q_W-1]) begin
            mant  = quot[MAN_W+1:2];
            guard = quot[1];
            e_pre = e_base;
        end else begin
            mant  = quot[MAN_W:1];
            guard = quot[0];
            e_pre = e_base - $signed(E_W'(1));
        end
        {carry, mant_rnd} = {1'b0, mant} + {{MAN_W{1'b0}}, guard};
        e_rnd = e_pre + $signed({{(E_W-1){1'b0}}, carry});

        if (zero_b) begin
            result_nxt = {sgn, EXP_W'(EXP_MAX), {MAN_W{1'b0}}};
        end else if (zero_a) begin
            result_nxt = {sgn, {(FP_W-1){1'b0}}};
        end else if (e_rnd >= E_MAX_S) begin
            result_nxt = {sgn, EXP_W'(EXP_MAX), {MAN_W{1'b0}}};
        end else if (e_rnd <= $signed(E_W'(0))) begin
            result_nxt = {sgn, {(FP_W-1){1'b0}}};
        end else begin
            result_nxt = {sgn, e_rnd[EXP_W-1:0], mant_rnd};
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            result_q     <= '0;
            result_rdy_q <= 1'b0;
        end else begin
            result_rdy_q <= load_result;
            if (load_result) begin
                result_q <= result_nxt;
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.result_rdy = result_rdy_q;
    assign bus.result     = result_q;

endmodule

// File: tb/tb_fp_division_bfloat16.sv
// Self-checking bench for fp_division_bfloat16: directed vectors, handshake and reset
// scenarios, then random operands compared against an arithmetic reference model.
// Outputs are sampled on the falling edge, inputs driven on the falling edge.
module tb_fp_division_bfloat16;
    import fp_bf25_pkg::*;

    logic clk;
    logic rstn;
    int   checks;
    int   errors;

    fp_division_bfloat16_if bus ();

    fp_division_bfloat16 dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer quotient of the real mantissas, then normalise/round/classify.
    function automatic logic [24:0] ref_div(input logic [24:0] a, input logic [24:0] b);
        logic   s;
        longint e1, e2, ma, mb, q, e, m, g;
        logic [7:0]  eo;
        logic [15:0] mo;
        s  = a[24] ^ b[24];
        e1 = longint'(a[23:16]);
        e2 = longint'(b[23:16]);
        if (e2 == 0) return {s, 8'hFF, 16'h0000};
        if (e1 == 0) return {s, 24'h000000};
        ma = 65536 + longint'(a[15:0]);
        mb = 65536 + longint'(b[15:0]);
        q  = (ma * 262144) / mb;
        e  = e1 - e2 + 127;
        if (q >= 262144) begin
            m = (q / 4) % 65536;
            g = (q / 2) % 2;
        end else begin
            m = (q / 2) % 65536;
            g = q % 2;
            e = e - 1;
        end
        m = m + g;
        if (m == 65536) begin
            m = 0;
            e = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 16'h0000};
        if (e <= 0)   return {s, 24'h000000};
        eo = 8'(e);
        mo = 16'(m);
        return {s, eo, mo};
    endfunction

    // One complete divide; optionally pokes strobes with other operands while busy.
    task automatic run_op(input logic [24:0] a, input logic [24:0] b,
                          input logic [24:0] exp, input string tag, input bit poke);
        int lat;
        int n;
        lat = -1;
        @(negedge clk);
        for (int w = 0; w < 50 && !bus.in_ready; w++) @(negedge clk);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.values_rdy = 1'b1;
        bus.fp_value_1 = a;
        bus.fp_value_2 = b;
        @(posedge clk);
        @(negedge clk);
        bus.values_rdy = 1'b0;
        for (n = 1; n <= 40; n++) begin
            if (poke && n == 3) begin
                bus.values_rdy = 1'b1;
                bus.fp_value_1 = 25'h0818000;
                bus.fp_value_2 = 25'h0000000;
            end
            if (poke && n == 6) begin
                check({tag, "_busy_in_ready"}, 32'(bus.in_ready), 32'd0);
                bus.values_rdy = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            if (bus.result_rdy) begin
                lat = n;
                break;
            end
        end
        bus.values_rdy = 1'b0;
        check({tag, "_latency"}, 32'(lat), 32'd20);
        check(tag, 32'(bus.result), 32'(exp));
    endtask

    initial begin
        int first, second, pulses;
        bit stable_bad;
        logic [24:0] ra, rb;

        checks = 0;
        errors = 0;
        rstn = 1'b0;
        bus.values_rdy = 1'b0;
        bus.fp_value_1 = '0;
        bus.fp_value_2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",   32'(bus.in_ready),   32'd1);
        check("rst_result_rdy", 32'(bus.result_rdy), 32'd0);
        check("rst_result",     32'(bus.result),     32'd0);
        rstn = 1'b1;

        // Directed vectors.
        run_op(25'h0818000, 25'h0808000, 25'h0800000, "six_div_three", 1'b0);
        run_op(25'h07F0000, 25'h07F4000, 25'h07E999A, "round_up",      1'b0);
        run_op(25'h07F0000, 25'h0808000, 25'h07D5555, "truncate",      1'b0);
        run_op(25'h0000000, 25'h07F0000, 25'h0000000, "zero_dividend", 1'b0);
        run_op(25'h07F0000, 25'h0000000, 25'h0FF0000, "zero_divisor",  1'b0);
        run_op(25'h0000000, 25'h0000000, 25'h0FF0000, "zero_by_zero",  1'b0);
        run_op(25'h1818000, 25'h0808000, 25'h1800000, "neg_six",       1'b0);
        run_op(25'h0FE0000, 25'h0010000, 25'h0FF0000, "overflow",      1'b0);
        run_op(25'h0010000, 25'h0FE0000, 25'h0000000, "underflow",     1'b0);
        run_op(25'h07F0000, 25'h0808000, 25'h07D5555, "busy_drop",     1'b1);
        @(negedge clk);
        check("busy_drop_idle", 32'(bus.in_ready), 32'd1);

        // values_rdy held high: back-to-back accepts 21 edges apart.
        @(negedge clk);
        bus.values_rdy = 1'b1;
        bus.fp_value_1 = 25'h0818000;
        bus.fp_value_2 = 25'h0808000;
        @(posedge clk);
        @(negedge clk);
        bus.fp_value_1 = 25'h07F0000;
        bus.fp_value_2 = 25'h07F4000;
        first = -1;
        second = -1;
        stable_bad = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.result_rdy) begin
                if (first < 0) begin
                    first = n;
                    check("held_first_result", 32'(bus.result), 32'h0800000);
                end else begin
                    second = n;
                    break;
                end
            end else if (first >= 0 && bus.result !== 25'h0800000) begin
                stable_bad = 1'b1;
            end
        end
        bus.values_rdy = 1'b0;
        check("held_first_latency",  32'(first),  32'd20);
        check("held_second_latency", 32'(second), 32'd41);
        check("held_second_result",  32'(bus.result), 32'h07E999A);
        check("held_result_stable",  32'(stable_bad), 32'd0);
        @(negedge clk);
        check("held_no_third", 32'(bus.in_ready), 32'd1);

        // Reset in the middle of a divide.
        run_op(25'h07F0000, 25'h0808000, 25'h07D5555, "pre_reset", 1'b0);
        @(negedge clk);
        bus.values_rdy = 1'b1;
        bus.fp_value_1 = 25'h0818000;
        bus.fp_value_2 = 25'h0808000;
        @(posedge clk);
        @(negedge clk);
        bus.values_rdy = 1'b0;
        repeat (9) begin
            @(posedge clk);
            @(negedge clk);
        end
        rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_result_rdy", 32'(bus.result_rdy), 32'd0);
        check("midrst_result",     32'(bus.result),     32'd0);
        check("midrst_in_ready",   32'(bus.in_ready),   32'd1);
        rstn = 1'b1;
        pulses = 0;
        repeat (30) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.result_rdy) pulses++;
        end
        check("midrst_no_pulse", 32'(pulses), 32'd0);
        run_op(25'h0818000, 25'h0808000, 25'h0800000, "post_reset", 1'b0);

        // Random operands against the reference model.
        for (int i = 0; i < 40; i++) begin
            ra = 25'($urandom);
            rb = 25'($urandom);
            if ($urandom_range(0, 9) == 0) ra[23:16] = 8'h00;
            if ($urandom_range(0, 9) == 0) rb[23:16] = 8'h00;
            if ($urandom_range(0, 1) == 0) ra[23:16] = 8'($urandom_range(100, 155));
            if ($urandom_range(0, 1) == 0) rb[23:16] = 8'($urandom_range(100, 155));
            run_op(ra, rb, ref_div(ra, rb), $sformatf("rand%0d_%h_%h", i, ra, rb), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
